// File: rtl/multi_pseudo_stick_pkg.sv
// Shared widths, parameter defaults and direction encoding for the pseudo-stick block.
package multi_pseudo_stick_pkg;

  localparam int NAX_DEF     = 4;
  localparam int STEP_DEF    = 15;
  localparam int LIMIT_DEF   = 120;
  localparam int CENTER_DEF  = 127;
  localparam int ACC_MAX_DEF = 15;

  localparam int POS_W   = 9;
  localparam int STEP_W  = 7;
  localparam int ARITH_W = 10;
  localparam int OUT_W   = 8;

  typedef logic signed [POS_W-1:0]   pos_t;
  typedef logic        [STEP_W-1:0]  step_t;
  typedef logic signed [ARITH_W-1:0] arith_t;

  // Encoded as a 2-bit signed value so DIR_NEG reads as -1.
  typedef enum logic [1:0] {
    DIR_NONE = 2'b00,
    DIR_POS  = 2'b01,
    DIR_NEG  = 2'b11
  } dir_e;

  function automatic dir_e decode_dir(input logic inc, input logic dec);
    dir_e d;
    case ({inc, dec})
      2'b10:   d = DIR_POS;
      2'b01:   d = DIR_NEG;
      default: d = DIR_NONE;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/pseudo_stick_axis.sv
// One axis: position/step/direction state, acceleration, spring or hold, clamp and output register.
module pseudo_stick_axis
  import multi_pseudo_stick_pkg::*;
#(
  parameter int STEP    = STEP_DEF,
  parameter int LIMIT   = LIMIT_DEF,
  parameter int CENTER  = CENTER_DEF,
  parameter int ACC_MAX = ACC_MAX_DEF,
  parameter bit HOLD    = 1'b0,
  parameter bit INV     = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             upd_i,
  input  logic             zero_i,
  input  logic             pinc_i,
  input  logic             pdec_i,
  output logic [OUT_W-1:0] aout_o
);

  localparam arith_t          LIM_P  = arith_t'(LIMIT);
  localparam arith_t          LIM_N  = -arith_t'(LIMIT);
  localparam arith_t          STEP_A = arith_t'(STEP);
  localparam logic [STEP_W:0] STEP_S = (STEP_W+1)'(STEP);
  localparam logic [STEP_W:0] ACC_S  = (STEP_W+1)'(ACC_MAX);

  pos_t             pos_q, pos_d;
  step_t            step_q, step_d;
  dir_e             dir_q, dir_d, dir_now;
  logic [OUT_W-1:0] aout_q, aout_d;
  logic [STEP_W:0]  step_sum;
  step_t            step_acc;
  arith_t           sum;

  always_comb begin
    pos_d    = pos_q;
    step_d   = step_q;
    dir_d    = dir_q;
    dir_now  = decode_dir(pinc_i, pdec_i);
    step_sum = {1'b0, step_q} + STEP_S;
    step_acc = (step_sum > ACC_S) ? step_t'(ACC_MAX) : step_sum[STEP_W-1:0];
    sum      = arith_t'(pos_q);

    if (zero_i) begin
      pos_d  = '0;
      step_d = step_t'(STEP);
      dir_d  = DIR_NONE;
    end else if (upd_i) begin
      dir_d  = dir_now;
      step_d = step_t'(STEP);
      if (dir_now == DIR_NONE) begin
        // Spring axes return by STEP and snap to zero rather than overshoot.
        if (HOLD)                sum = arith_t'(pos_q);
        else if (sum > STEP_A)   sum = sum - STEP_A;
        else if (sum < -STEP_A)  sum = sum + STEP_A;
        else                     sum = '0;
      end else begin
        if (dir_now == dir_q) step_d = step_acc;
        if (dir_now == DIR_POS) sum = sum + arith_t'(step_d);
        else                    sum = sum - arith_t'(step_d);
      end
      if (sum > LIM_P)      pos_d = pos_t'(LIM_P);
      else if (sum < LIM_N) pos_d = pos_t'(LIM_N);
      else                  pos_d = pos_t'(sum);
    end

    if (INV) aout_d = OUT_W'(CENTER - int'(pos_d));
    else     aout_d = OUT_W'(CENTER + int'(pos_d));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pos_q  <= '0;
      step_q <= step_t'(STEP);
      dir_q  <= DIR_NONE;
      aout_q <= OUT_W'(CENTER);
    end else begin
      pos_q  <= pos_d;
      step_q <= step_d;
      dir_q  <= dir_d;
      aout_q <= aout_d;
    end
  end

  assign aout_o = aout_q;

endmodule

// File: rtl/multi_pseudo_stick.sv
// Button-driven pseudo analog sticks: TICK rising-edge detect, UPD pulse and NAX axis instances.
module multi_pseudo_stick
  import multi_pseudo_stick_pkg::*;
#(
  parameter int             NAX       = NAX_DEF,
  parameter int             STEP      = STEP_DEF,
  parameter int             LIMIT     = LIMIT_DEF,
  parameter int             CENTER    = CENTER_DEF,
  parameter int             ACC_MAX   = ACC_MAX_DEF,
  parameter logic [NAX-1:0] HOLD_MASK = '0,
  parameter logic [NAX-1:0] INV_MASK  = '0
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               TICK,
  input  logic               ZERO,
  input  logic [NAX-1:0]     PINC,
  input  logic [NAX-1:0]     PDEC,
  output logic [8*NAX-1:0]   AOUT,
  output logic               UPD
);

  logic tick_q;
  logic upd_q;
  logic upd_cycle;

  // tick_q resets high so a TICK already asserted at reset release is not an edge.
  assign upd_cycle = TICK & ~tick_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      tick_q <= 1'b1;
      upd_q  <= 1'b0;
    end else begin
      tick_q <= TICK;
      upd_q  <= upd_cycle;
    end
  end

  assign UPD = upd_q;

  for (genvar i = 0; i < NAX; i++) begin : g_axis
    pseudo_stick_axis #(
      .STEP    (STEP),
      .LIMIT   (LIMIT),
      .CENTER  (CENTER),
      .ACC_MAX (ACC_MAX),
      .HOLD    (HOLD_MASK[i]),
      .INV     (INV_MASK[i])
    ) u_axis (
      .clk_i  (CLK),
      .rst_ni (RESET_N),
      .upd_i  (upd_cycle),
      .zero_i (ZERO),
      .pinc_i (PINC[i]),
      .pdec_i (PDEC[i]),
      .aout_o (AOUT[8*i +: 8])
    );
  end

endmodule

// File: tb/tb_multi_pseudo_stick.sv
// Directed bench: three stick configurations sharing clock, reset, TICK and ZERO.
module tb_multi_pseudo_stick;

  logic        clk = 1'b0;
  logic        rst_n, tick, zero;
  logic [3:0]  pinc_a, pdec_a, pinc_b, pdec_b, pinc_c, pdec_c;
  logic [31:0] aout_a, aout_b, aout_c;
  logic        upd_a, upd_b, upd_c;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  multi_pseudo_stick #(.HOLD_MASK(4'b0100), .INV_MASK(4'b0100)) dut_a (
    .CLK(clk), .RESET_N(rst_n), .TICK(tick), .ZERO(zero),
    .PINC(pinc_a), .PDEC(pdec_a), .AOUT(aout_a), .UPD(upd_a));

  multi_pseudo_stick #(.ACC_MAX(45)) dut_b (
    .CLK(clk), .RESET_N(rst_n), .TICK(tick), .ZERO(zero),
    .PINC(pinc_b), .PDEC(pdec_b), .AOUT(aout_b), .UPD(upd_b));

  multi_pseudo_stick #(.STEP(20), .ACC_MAX(30)) dut_c (
    .CLK(clk), .RESET_N(rst_n), .TICK(tick), .ZERO(zero),
    .PINC(pinc_c), .PDEC(pdec_c), .AOUT(aout_c), .UPD(upd_c));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One TICK pulse: AOUT/UPD are sampled 1ns after the update edge, UPD again a cycle later.
  task automatic do_tick(input string tag);
    @(negedge clk); tick = 1'b1;
    @(posedge clk); #1;
    check({tag, "_upd"}, {31'd0, upd_a}, 32'd1);
    @(negedge clk); tick = 1'b0;
    @(posedge clk); #1;
    check({tag, "_upd_clr"}, {31'd0, upd_a}, 32'd0);
  endtask

  initial begin
    int exp_c[10] = '{147, 177, 157, 137, 127, 127, 127, 127, 127, 127};
    int exp_b[4]  = '{112, 82, 37, 7};
    int e;

    rst_n = 1'b0; tick = 1'b0; zero = 1'b0;
    pinc_a = '0; pdec_a = '0; pinc_b = '0; pdec_b = '0; pinc_c = '0; pdec_c = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_aout_a", aout_a, 32'h7F7F7F7F);
    check("rst_aout_b", aout_b, 32'h7F7F7F7F);
    check("rst_aout_c", aout_c, 32'h7F7F7F7F);
    check("rst_upd", {29'd0, upd_a, upd_b, upd_c}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Push to the clamp; C gets two pushes then springs back from +50.
    pinc_a[0] = 1'b1; pinc_c[0] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      if (k == 3) pinc_c[0] = 1'b0;
      do_tick($sformatf("push_t%0d", k));
      e = (127 + 15 * k > 247) ? 247 : 127 + 15 * k;
      check($sformatf("push_a0_t%0d", k), {24'd0, aout_a[7:0]}, e);
      check($sformatf("spring_c0_t%0d", k), {24'd0, aout_c[7:0]}, exp_c[k-1]);
      if (k == 4) begin
        // Button glitch between ticks must not be seen.
        @(negedge clk); pinc_a[0] = 1'b0; pdec_a[0] = 1'b1;
        repeat (2) @(negedge clk);
        pdec_a[0] = 1'b0; pinc_a[0] = 1'b1;
        @(posedge clk); #1;
        check("between_ticks_a0", {24'd0, aout_a[7:0]}, 32'd187);
        check("between_ticks_upd", {31'd0, upd_a}, 32'd0);
      end
    end

    pinc_a[0] = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      do_tick($sformatf("rel_t%0d", k));
      e = (247 - 15 * k < 127) ? 127 : 247 - 15 * k;
      check($sformatf("release_a0_t%0d", k), {24'd0, aout_a[7:0]}, e);
    end

    // Acceleration toward the negative clamp, then reversal.
    pdec_b[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      do_tick($sformatf("acc_t%0d", k));
      check($sformatf("accel_b1_t%0d", k), {24'd0, aout_b[15:8]}, exp_b[k]);
    end
    pdec_b[1] = 1'b0; pinc_b[1] = 1'b1;
    do_tick("rev");
    check("reverse_b1", {24'd0, aout_b[15:8]}, 32'd22);
    check("reverse_b0_idle", {24'd0, aout_b[7:0]}, 32'd127);
    pinc_b[1] = 1'b0;

    // Hold + inverted axis, then a ZERO pulse with no tick.
    pinc_a[2] = 1'b1;
    do_tick("hold1"); check("hold_a2_t1", {24'd0, aout_a[23:16]}, 32'd112);
    do_tick("hold2"); check("hold_a2_t2", {24'd0, aout_a[23:16]}, 32'd97);
    pinc_a[2] = 1'b0;
    do_tick("hold3"); check("hold_a2_t3", {24'd0, aout_a[23:16]}, 32'd97);
    do_tick("hold4"); check("hold_a2_t4", {24'd0, aout_a[23:16]}, 32'd97);
    @(negedge clk); zero = 1'b1;
    @(posedge clk); #1;
    check("zero_a2", {24'd0, aout_a[23:16]}, 32'd127);
    check("zero_no_upd", {31'd0, upd_a}, 32'd0);
    @(negedge clk); zero = 1'b0;

    // ZERO coincident with a tick wins, but UPD still pulses.
    pinc_a[0] = 1'b1;
    do_tick("zc1"); check("zc_a0_pre", {24'd0, aout_a[7:0]}, 32'd142);
    @(negedge clk); tick = 1'b1; zero = 1'b1;
    @(posedge clk); #1;
    check("zc_a0_zero", {24'd0, aout_a[7:0]}, 32'd127);
    check("zc_upd", {31'd0, upd_a}, 32'd1);
    @(negedge clk); tick = 1'b0; zero = 1'b0;
    do_tick("zc2"); check("zc_a0_after", {24'd0, aout_a[7:0]}, 32'd142);
    pinc_a[0] = 1'b0;
    do_tick("zc3"); check("zc_a0_rel", {24'd0, aout_a[7:0]}, 32'd127);

    // Both buttons on axis 3 count as released.
    pinc_a[3] = 1'b1;
    do_tick("both1"); check("both_a3_t1", {24'd0, aout_a[31:24]}, 32'd142);
    do_tick("both2"); check("both_a3_t2", {24'd0, aout_a[31:24]}, 32'd157);
    pdec_a[3] = 1'b1;
    do_tick("both3"); check("both_a3_t3", {24'd0, aout_a[31:24]}, 32'd142);
    do_tick("both4"); check("both_a3_t4", {24'd0, aout_a[31:24]}, 32'd127);
    do_tick("both5"); check("both_a3_t5", {24'd0, aout_a[31:24]}, 32'd127);
    pinc_a[3] = 1'b0; pdec_a[3] = 1'b0;

    // Reset during a tick cycle, released with TICK still high.
    pinc_a[0] = 1'b1;
    do_tick("rr1"); check("rr_a0_t1", {24'd0, aout_a[7:0]}, 32'd142);
    do_tick("rr2"); check("rr_a0_t2", {24'd0, aout_a[7:0]}, 32'd157);
    @(negedge clk); tick = 1'b1; rst_n = 1'b0;
    #1;
    check("rr_async_aout", aout_a, 32'h7F7F7F7F);
    @(posedge clk); #1;
    check("rr_aout", aout_a, 32'h7F7F7F7F);
    check("rr_upd", {31'd0, upd_a}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rr_no_spurious_upd", {31'd0, upd_a}, 32'd0);
    check("rr_no_spurious_aout", aout_a, 32'h7F7F7F7F);
    @(negedge clk); tick = 1'b0;
    do_tick("rr3"); check("rr_first_after", {24'd0, aout_a[7:0]}, 32'd142);

    // Back-to-back ticks two cycles apart: one update each.
    @(negedge clk); tick = 1'b1;
    @(posedge clk); #1;
    check("fast_a0_1", {24'd0, aout_a[7:0]}, 32'd157);
    check("fast_upd_1", {31'd0, upd_a}, 32'd1);
    @(negedge clk); tick = 1'b0;
    @(negedge clk); tick = 1'b1;
    @(posedge clk); #1;
    check("fast_a0_2", {24'd0, aout_a[7:0]}, 32'd172);
    check("fast_upd_2", {31'd0, upd_a}, 32'd1);
    @(negedge clk); tick = 1'b0;
    @(posedge clk); #1;
    check("fast_upd_clr", {31'd0, upd_a}, 32'd0);
    check("fast_upd_bc", {30'd0, upd_b, upd_c}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_pseudo_stick.md
MULTI_PSEUDO_STICK -- requirements
Module: multi_pseudo_stick

Interface
REQ-001 Parameter NAX, default 4: number of independent axes, 1..16; two axes form one stick (even index X, odd index Y).
REQ-002 Parameter STEP, default 15: base position increment per tick, 1..63.
REQ-003 Parameter LIMIT, default 120: magnitude clamp, 1..127.
REQ-004 Parameter CENTER, default 127: output value at rest; CENTER-LIMIT >= 0 and CENTER+LIMIT <= 255.
REQ-005 Parameter ACC_MAX, default 15: maximum step under acceleration, STEP..127; ACC_MAX=STEP disables acceleration.
REQ-006 Parameter HOLD_MASK, default 0, NAX bits: bit set = axis holds position on release; bit clear = axis springs back to centre.
REQ-007 Parameter INV_MASK, default 0, NAX bits: bit set = output mirrored as CENTER-pos.
REQ-008 CLK  input  1  system clock.
REQ-009 RESET_N  input  1  asynchronous, active-low reset.
REQ-010 TICK  input  1  update strobe level (e.g. VBLANK); the rising edge is sampled in the CLK domain.
REQ-011 ZERO  input  1  synchronous recentre of all axes.
REQ-012 PINC  input  NAX  per-axis "push positive" button, active high.
REQ-013 PDEC  input  NAX  per-axis "push negative" button, active high.
REQ-014 AOUT  output  8*NAX  unsigned axis values; axis i occupies bits [8i+7:8i].
REQ-015 UPD  output  1  one-cycle pulse, asserted in the cycle that AOUT changes after a tick.

Function
REQ-016 Internal position per axis: signed 9-bit, range -LIMIT..+LIMIT. Internal step per axis: unsigned 7-bit.
REQ-017 Tick detect: TICK is registered once; the update cycle is the first cycle where the registered value is 0 and TICK is 1.
REQ-018 Direction per axis on the update cycle:
- PINC only -> +1
- PDEC only -> -1
- both or neither -> 0 (released)
REQ-019 Held direction, same as the previous update: step <- min(step+STEP, ACC_MAX); pos <- pos + dir*step, using the new step.
REQ-020 Held direction, new or reversed: step <- STEP; pos <- pos + dir*STEP.
REQ-021 Released, spring axis: step <- STEP; pos moves toward 0 by STEP; if |pos| <= STEP, pos <- 0 with no overshoot.
REQ-022 Released, hold axis: pos unchanged; step <- STEP.
REQ-023 Clamp: after the add, pos is saturated to ±LIMIT. Arithmetic uses 10-bit intermediate so no wrap-around is possible.
REQ-024 AOUT is registered and updates one cycle after the update cycle: AOUT = CENTER+pos, or CENTER-pos if the INV_MASK bit is set. UPD pulses in that same cycle.
REQ-025 ZERO high on a CLK edge:
- all pos <- 0, step <- STEP, remembered direction <- 0
- AOUT <- CENTER on the next cycle
- ZERO has priority over a coincident update cycle; UPD still pulses for that tick.
REQ-026 Button changes between ticks have no effect. Only values sampled on the update cycle count.
REQ-027 Consecutive TICK edges closer than 2 cycles: each detected edge performs exactly one update.

Reset
REQ-028 While RESET_N=0:
- pos = 0, step = STEP, remembered direction = 0
- TICK register = 1, so a TICK already high at release is not an edge
- AOUT = CENTER on all axes
- UPD = 0
REQ-029 Reset asserted mid-update abandons the update. The first update after release uses reset state.

Structure
REQ-030 Package multi_pseudo_stick_pkg holds the parameter defaults, the position/step widths and the direction encoding constants.
REQ-031 Sub-module pseudo_stick_axis implements one axis (pos, step, direction regs, output reg). The top holds tick detect and UPD, and generates NAX instances.
REQ-032 Target size: about 150-300 RTL lines total.

Verification
REQ-033 Defaults, PINC[0] held for 10 ticks -> AOUT[7:0] = 142,157,...,247 clamped: 9th and 10th ticks read 247; UPD pulses once per tick.
REQ-034 Defaults, after pos=+120, release PINC[0] -> AOUT[7:0] steps 232,217,...,127 and stays at 127 with no overshoot. With STEP=20 from pos=+50 -> 157,137,127.
REQ-035 ACC_MAX=45, PDEC[1] held -> AOUT[15:8] = 112,82,37,7 (clamped at -120); reversing to PINC gives +15 from the clamp -> 22.
REQ-036 HOLD_MASK[2]=1, INV_MASK[2]=1: PINC[2] for 2 ticks then release -> AOUT[23:16] = 112,97,97,97. Then ZERO pulse -> 127 next cycle.
REQ-037 PINC[3] and PDEC[3] both high -> treated as released; AOUT[31:24] springs toward 127. Separately, RESET_N low during a tick cycle -> AOUT=127 on all axes, UPD=0, and no spurious update at release with TICK high.
